// File: rtl/pipe_stage_hs_if.sv
// Handshake bundle for one pipeline stage boundary.
//   flush_i      : synchronous flush request into the stage
//   in_valid_i   : upstream payload valid
//   in_ready_o   : stage can accept (registered inside the stage)
//   in_data_i    : upstream payload
//   out_valid_o  : payload valid to downstream
//   out_ready_i  : downstream accepts
//   out_data_o   : payload to downstream (NOP when not valid)
//   count_o      : stage occupancy, 0..2
// The slave modport is the stage's view; master is the driver's view.
interface pipe_stage_hs_if #(
  parameter int DATA_W = 64
) ();
  logic              flush_i;
  logic              in_valid_i;
  logic              in_ready_o;
  logic [DATA_W-1:0] in_data_i;
  logic              out_valid_o;
  logic              out_ready_i;
  logic [DATA_W-1:0] out_data_o;
  logic [1:0]        count_o;

  modport slave (
    input  flush_i, in_valid_i, in_data_i, out_ready_i,
    output in_ready_o, out_valid_o, out_data_o, count_o
  );

  modport master (
    output flush_i, in_valid_i, in_data_i, out_ready_i,
    input  in_ready_o, out_valid_o, out_data_o, count_o
  );
endinterface

// File: rtl/pipe_stage_hs.sv
// Pipeline stage register with valid/ready handshake, a two-entry skid
// buffer and synchronous flush to a NOP bubble.
// Ports:
//   clk  : clock, all state changes on the rising edge
//   rst  : synchronous reset, active-low
//   bus  : pipe_stage_hs_if.slave carrying flush, both handshakes,
//          the payload in/out and the occupancy count
// The main register always holds the head entry and drives out_data_o;
// the skid register catches the one item that arrives while downstream
// stalls. in_ready_o is a flop, so out_ready_i never reaches upstream
// combinationally.
module pipe_stage_hs #(
  parameter int                DATA_W    = 64,
  parameter logic [DATA_W-1:0] NOP_VALUE = DATA_W'(64'h00000013_00000000)
) (
  input logic             clk,
  input logic             rst,
  pipe_stage_hs_if.slave  bus
);

  // State encoding equals the occupancy count, so count_o is the state.
  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] ONE   = 2'd1;
  localparam logic [1:0] TWO   = 2'd2;

  logic [1:0]        state_q, state_d;
  logic              ready_q, ready_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              in_fire;
  logic              out_fire;

  assign in_fire  = bus.in_valid_i & ready_q;
  assign out_fire = (state_q != EMPTY) & bus.out_ready_i;

  // Next-state and payload routing. Flush overrides every transition and
  // drops whatever was offered in the same cycle.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      EMPTY: begin
        if (in_fire) begin
          state_d = ONE;
          main_d  = bus.in_data_i;
        end
      end
      ONE: begin
        if (in_fire && out_fire) begin
          main_d = bus.in_data_i;
        end else if (in_fire) begin
          state_d = TWO;
          skid_d  = bus.in_data_i;
        end else if (out_fire) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        if (out_fire) begin
          state_d = ONE;
          main_d  = skid_q;
        end
      end
      default: state_d = EMPTY;
    endcase
    if (bus.flush_i) begin
      state_d = EMPTY;
    end
    ready_d = (state_d != TWO);
  end

  // Control state; reset holds ready low until the first edge out of reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= EMPTY;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
    end
  end

  // Payload registers need no reset: the output mux hides them when empty.
  always_ff @(posedge clk) begin
    main_q <= main_d;
    skid_q <= skid_d;
  end

  assign bus.in_ready_o  = ready_q;
  assign bus.out_valid_o = (state_q != EMPTY);
  assign bus.out_data_o  = (state_q != EMPTY) ? main_q : NOP_VALUE;
  assign bus.count_o     = state_q;

endmodule

// File: tb/tb_pipe_stage_hs.sv
// Bench for pipe_stage_hs: a 64-bit and an 8-bit instance share the same
// control stimulus; the 8-bit one sees the low byte of each payload.
// A depth-2 queue model predicts every output on every cycle.
module tb_pipe_stage_hs;

  localparam logic [63:0] NOP64 = 64'h00000013_00000000;
  localparam logic [7:0]  NOP8  = NOP64[7:0];

  localparam logic [63:0] SA = {32'h00500093, 32'h0};
  localparam logic [63:0] SB = {32'h00100113, 32'h4};
  localparam logic [63:0] SC = {32'h002081B3, 32'h8};
  localparam logic [63:0] SD = {32'h00000033, 32'hC};

  logic clk;
  logic rst;
  int   nCompared;
  int   nMismatched;

  pipe_stage_hs_if #(.DATA_W(64)) bus64 ();
  pipe_stage_hs_if #(.DATA_W(8))  bus8 ();

  pipe_stage_hs #(.DATA_W(64)) dut64 (.clk(clk), .rst(rst), .bus(bus64));
  pipe_stage_hs #(.DATA_W(8))  dut8  (.clk(clk), .rst(rst), .bus(bus8));

  assign bus8.flush_i     = bus64.flush_i;
  assign bus8.in_valid_i  = bus64.in_valid_i;
  assign bus8.in_data_i   = bus64.in_data_i[7:0];
  assign bus8.out_ready_i = bus64.out_ready_i;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: an ordered list of held entries plus the ready flop.
  logic [63:0] q[$];
  bit          expRdy;
  bit          live;

  initial begin
    expRdy = 1'b0;
    live   = 1'b0;
  end

  // Model update on every rising edge using the inputs the DUT sees.
  always @(posedge clk) begin
    bit inFire;
    bit outFire;
    live = 1'b1;
    if (!rst) begin
      q.delete();
      expRdy = 1'b0;
    end else if (bus64.flush_i) begin
      q.delete();
      expRdy = 1'b1;
    end else begin
      inFire  = bus64.in_valid_i && expRdy;
      outFire = (q.size() != 0) && bus64.out_ready_i;
      if (outFire) void'(q.pop_front());
      if (inFire) q.push_back(bus64.in_data_i);
      expRdy = (q.size() < 2);
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] act,
                             input logic [63:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input bit r, input bit f, input bit v,
                               input bit rdy, input logic [63:0] d);
    rst               = r;
    bus64.flush_i     = f;
    bus64.in_valid_i  = v;
    bus64.out_ready_i = rdy;
    bus64.in_data_i   = d;
    @(posedge clk);
    #2;
  endtask

  // Per-cycle comparison against the model, plus an independent check that
  // a stalled head entry does not change.
  logic [63:0] holdData;
  bit          holdPending;
  initial holdPending = 1'b0;

  always @(negedge clk) begin
    logic [63:0] e64;
    if (live) begin
      e64 = (q.size() != 0) ? q[0] : NOP64;
      checkOutput("valid64", 64'(bus64.out_valid_o), 64'(q.size() != 0));
      checkOutput("data64",  bus64.out_data_o, e64);
      checkOutput("count64", 64'(bus64.count_o), 64'(q.size()));
      checkOutput("ready64", 64'(bus64.in_ready_o), 64'(expRdy));
      checkOutput("valid8",  64'(bus8.out_valid_o), 64'(q.size() != 0));
      checkOutput("data8",   64'(bus8.out_data_o),
                  64'((q.size() != 0) ? e64[7:0] : NOP8));
      checkOutput("count8",  64'(bus8.count_o), 64'(q.size()));
      checkOutput("ready8",  64'(bus8.in_ready_o), 64'(expRdy));
      if (holdPending) checkOutput("stable64", bus64.out_data_o, holdData);
      holdPending = bus64.out_valid_o && !bus64.out_ready_i && rst && !bus64.flush_i;
      holdData    = bus64.out_data_o;
    end
  end

  initial begin
    nCompared   = 0;
    nMismatched = 0;

    // Reset held with input offered: nothing may be accepted.
    repeat (3) begin
      applyStimulus(0, 0, 1, 0, 64'hDEAD);
      checkOutput("rstValid", 64'(bus64.out_valid_o), 64'd0);
      checkOutput("rstData",  bus64.out_data_o, 64'h00000013_00000000);
      checkOutput("rstReady", 64'(bus64.in_ready_o), 64'd0);
      checkOutput("rstCount", 64'(bus64.count_o), 64'd0);
    end
    applyStimulus(1, 0, 1, 0, 64'hDEAD);
    checkOutput("relReady", 64'(bus64.in_ready_o), 64'd1);
    checkOutput("relCount", 64'(bus64.count_o), 64'd0);

    // Streaming at full rate.
    applyStimulus(1, 0, 1, 1, SA);
    checkOutput("strA", bus64.out_data_o, SA);
    checkOutput("strCnt", 64'(bus64.count_o), 64'd1);
    applyStimulus(1, 0, 1, 1, SB);
    checkOutput("strB", bus64.out_data_o, SB);
    checkOutput("strB8", 64'(bus8.out_data_o), 64'h04);
    applyStimulus(1, 0, 1, 1, SC);
    checkOutput("strC", bus64.out_data_o, SC);
    checkOutput("strRdy", 64'(bus64.in_ready_o), 64'd1);
    applyStimulus(1, 0, 0, 1, 64'd0);
    checkOutput("strEnd", bus64.out_data_o, NOP64);

    // Stall absorption then drain.
    applyStimulus(1, 0, 1, 0, SA);
    applyStimulus(1, 0, 1, 0, SB);
    checkOutput("stlCnt", 64'(bus64.count_o), 64'd2);
    checkOutput("stlRdy", 64'(bus64.in_ready_o), 64'd0);
    applyStimulus(1, 0, 1, 0, SC);
    checkOutput("stlHeadA", bus64.out_data_o, SA);
    applyStimulus(1, 0, 1, 1, SC);
    checkOutput("drnB", bus64.out_data_o, SB);
    applyStimulus(1, 0, 1, 1, SC);
    checkOutput("drnC", bus64.out_data_o, SC);
    applyStimulus(1, 0, 0, 1, 64'd0);
    checkOutput("drnEnd", 64'(bus64.out_valid_o), 64'd0);

    // Flush while full, with a new item offered in the flush cycle.
    applyStimulus(1, 0, 1, 0, SA);
    applyStimulus(1, 0, 1, 0, SB);
    applyStimulus(1, 1, 1, 0, SC);
    checkOutput("flCnt",  64'(bus64.count_o), 64'd0);
    checkOutput("flData", bus64.out_data_o, NOP64);
    checkOutput("flRdy",  64'(bus64.in_ready_o), 64'd1);
    applyStimulus(1, 0, 1, 0, SD);
    checkOutput("flD", bus64.out_data_o, SD);
    applyStimulus(1, 0, 0, 1, 64'd0);

    // Reset while full; the skid entry must never surface.
    applyStimulus(1, 0, 1, 0, SA);
    applyStimulus(1, 0, 1, 0, SB);
    applyStimulus(0, 0, 0, 0, 64'd0);
    checkOutput("msCnt",  64'(bus64.count_o), 64'd0);
    checkOutput("msData", bus64.out_data_o, NOP64);
    checkOutput("msRdy",  64'(bus64.in_ready_o), 64'd0);
    applyStimulus(1, 0, 0, 1, 64'd0);
    checkOutput("msRel", bus64.out_data_o, NOP64);
    applyStimulus(1, 0, 0, 1, 64'd0);
    checkOutput("msNoSkid", 64'(bus64.out_valid_o), 64'd0);

    // Randomised traffic with ~5% flush and rare resets.
    for (int i = 0; i < 10000; i++) begin
      applyStimulus(($urandom_range(0, 499) != 0),
                    ($urandom_range(0, 99) < 5),
                    1'($urandom_range(0, 1)),
                    ($urandom_range(0, 3) != 0),
                    {$urandom, $urandom});
    end
    applyStimulus(1, 0, 0, 1, 64'd0);
    applyStimulus(1, 0, 0, 1, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
